// File: rtl/count_sampler_pkg.sv
// Shared types and helpers for the counter sampler: checker states and the
// wrapping increment used to form the expected next sample.
package count_sampler_pkg;

    localparam int unsigned CNT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_e;

    // Callers truncate the result to their own width, which gives the modulo wrap.
    function automatic logic [CNT_MAX_W-1:0] next_cnt(input logic [CNT_MAX_W-1:0] v);
        return v + CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small sample buffer with a registered head. Pointers carry one extra bit
// so that the full and empty conditions can be told apart.
module sample_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/count_sampler.sv
// Samples an upstream free-running counter every cycle, checks that it steps
// by one (modulo 2^WIDTH), and forwards the samples over valid/ready.
module count_sampler
    import count_sampler_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     cnt_i,
    input  logic                 cnt_vld_i,
    output logic [WIDTH-1:0]     smp_data_o,
    output logic                 smp_vld_o,
    input  logic                 smp_rdy_i,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 ovf_o
);

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH-1:0]     exp_q;
    logic [WIDTH-1:0]     exp_d;
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign pop = !fifo_empty && smp_rdy_i;

    // Checker: every valid sample is pushed; only samples after the first are compared.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        push      = 1'b0;

        if (cnt_vld_i) begin
            push  = 1'b1;
            exp_d = WIDTH'(next_cnt(CNT_MAX_W'(cnt_i)));
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end
                TRACK, RESYNC: begin
                    if (cnt_i != exp_q) begin
                        err_d   = 1'b1;
                        state_d = RESYNC;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end else begin
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    sample_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cnt_i),
        .pop       (pop),
        .head      (smp_data_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign smp_vld_o = !fifo_empty;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_count_sampler.sv
// Bench for count_sampler: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_count_sampler;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int EW   = 8;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  cnt_drv;
    logic [W-1:0]  fr_cnt;
    logic          free_run;
    logic [W-1:0]  cnt_i;
    logic          cnt_vld_i;
    logic          smp_rdy_i;
    logic [W-1:0]  smp_data_o;
    logic          smp_vld_o;
    logic          err_o;
    logic [EW-1:0] err_cnt_o;
    logic          ovf_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q[$];
    bit m_started;
    int m_exp;
    bit m_err;
    int m_errcnt;
    bit m_ovf;

    always #5 clk = ~clk;

    // Upstream counter that updates on the same edge the DUT samples on.
    always @(posedge clk) begin
        if (free_run) fr_cnt <= fr_cnt + 8'd1;
        else          fr_cnt <= cnt_drv;
    end

    assign cnt_i = free_run ? fr_cnt : cnt_drv;

    count_sampler #(.WIDTH(W), .FIFO_DEPTH(D), .ERR_CNT_W(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_i      (cnt_i),
        .cnt_vld_i  (cnt_vld_i),
        .smp_data_o (smp_data_o),
        .smp_vld_o  (smp_vld_o),
        .smp_rdy_i  (smp_rdy_i),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o),
        .ovf_o      (ovf_o)
    );

    function automatic void model_edge(input int c, input bit v, input bit r, input bit rs);
        bit pop;
        if (rs) begin
            m_q.delete();
            m_started = 0; m_exp = 0; m_err = 0; m_errcnt = 0; m_ovf = 0;
            return;
        end
        pop = (m_q.size() > 0) && r;
        if (pop) void'(m_q.pop_front());
        if (v) begin
            if (m_started && c != m_exp) begin
                m_err = 1;
                if (m_errcnt < EMAX) m_errcnt++;
            end
            m_started = 1;
            m_exp = (c + 1) % (1 << W);
            if (m_q.size() < D) m_q.push_back(c);
            else m_ovf = 1;
        end
    endfunction

    // Apply inputs, let one rising edge happen, update the model, settle.
    task automatic step(input int c, input bit v, input bit r, input bit rs);
        int cs;
        cnt_drv   = W'(c);
        cnt_vld_i = v;
        smp_rdy_i = r;
        rst       = rs;
        cs = free_run ? int'(fr_cnt) : c;
        @(posedge clk);
        model_edge(cs, v, r, rs);
        #1;
    endtask

    task automatic test_reset();
        free_run = 0;
        step(0, 0, 0, 1);
        checks++; if (smp_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", smp_vld_o); end
        checks++; if (smp_data_o !== 8'd0) begin errors++; $display("FAIL reset_data got %0d want 0", smp_data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
        checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_cnt_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf_o); end
    endtask

    task automatic test_basic();
        step(0, 0, 0, 1);
        for (int c = 5; c <= 8; c++) begin
            step(c, 1, 1, 0);
            checks++; if (smp_vld_o !== 1'b1) begin errors++; $display("FAIL basic_vld c=%0d got %0b want 1", c, smp_vld_o); end
            checks++; if (smp_data_o !== 8'(c)) begin errors++; $display("FAIL basic_data got %0d want %0d", smp_data_o, c); end
        end
        step(0, 0, 1, 0);
        checks++; if (smp_vld_o !== 1'b0) begin errors++; $display("FAIL basic_drain_vld got %0b want 0", smp_vld_o); end
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin errors++; $display("FAIL basic_err got %0b/%0d want 0/0", err_o, err_cnt_o); end
    endtask

    task automatic test_wrap();
        int seq[4] = '{254, 255, 0, 1};
        step(0, 0, 0, 1);
        foreach (seq[i]) begin
            step(seq[i], 1, 1, 0);
            checks++; if (smp_data_o !== 8'(seq[i])) begin errors++; $display("FAIL wrap_data got %0d want %0d", smp_data_o, seq[i]); end
            checks++; if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin errors++; $display("FAIL wrap_err at %0d got %0b/%0d want 0/0", seq[i], err_o, err_cnt_o); end
        end
    endtask

    task automatic test_skip();
        int seq[4]  = '{10, 11, 13, 14};
        int werr[4] = '{0, 0, 1, 1};
        step(0, 0, 0, 1);
        foreach (seq[i]) begin
            step(seq[i], 1, 1, 0);
            checks++; if (smp_data_o !== 8'(seq[i])) begin errors++; $display("FAIL skip_data got %0d want %0d", smp_data_o, seq[i]); end
            checks++; if (err_o !== 1'(werr[i]) || err_cnt_o !== 8'(werr[i])) begin
                errors++; $display("FAIL skip_err at %0d got %0b/%0d want %0d/%0d", seq[i], err_o, err_cnt_o, werr[i], werr[i]);
            end
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 1);
        for (int c = 0; c < 6; c++) step(c, 1, 0, 0);
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (smp_vld_o !== 1'b1 || smp_data_o !== 8'(i)) begin
                errors++; $display("FAIL ovf_drain got vld=%0b data=%0d want vld=1 data=%0d", smp_vld_o, smp_data_o, i);
            end
            step(0, 0, 1, 0);
        end
        checks++; if (smp_vld_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", smp_vld_o); end
        // Full buffer with push and pop in the same cycle must not drop.
        step(0, 0, 0, 1);
        for (int c = 0; c < 4; c++) step(c, 1, 0, 0);
        step(4, 1, 1, 0);
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %0b want 0", ovf_o); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (smp_vld_o !== 1'b1 || smp_data_o !== 8'(i)) begin
                errors++; $display("FAIL fullpp_drain got vld=%0b data=%0d want vld=1 data=%0d", smp_vld_o, smp_data_o, i);
            end
            step(0, 0, 1, 0);
        end
        checks++; if (smp_vld_o !== 1'b0) begin errors++; $display("FAIL fullpp_empty got %0b want 0", smp_vld_o); end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step((i % 2) ? 5 : 0, 1, 1, 0);
        checks++; if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", err_cnt_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL sat_err got %0b want 1", err_o); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1);
        step(10, 1, 0, 0); step(11, 1, 0, 0); step(13, 1, 0, 0);
        checks++; if (err_o !== 1'b1 || smp_vld_o !== 1'b1) begin errors++; $display("FAIL mid_pre got err=%0b vld=%0b want 1/1", err_o, smp_vld_o); end
        step(0, 0, 0, 1);
        checks++; if ({smp_vld_o, smp_data_o, err_o, err_cnt_o, ovf_o} !== '0) begin
            errors++; $display("FAIL mid_zero got vld=%0b data=%0d err=%0b cnt=%0d ovf=%0b want all 0", smp_vld_o, smp_data_o, err_o, err_cnt_o, ovf_o);
        end
        step(99, 1, 1, 0);
        checks++; if (err_o !== 1'b0 || smp_data_o !== 8'd99) begin errors++; $display("FAIL mid_99 got err=%0b data=%0d want 0/99", err_o, smp_data_o); end
        step(100, 1, 1, 0);
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 8'd0 || smp_data_o !== 8'd100) begin
            errors++; $display("FAIL mid_100 got err=%0b cnt=%0d data=%0d want 0/0/100", err_o, err_cnt_o, smp_data_o);
        end
    endtask

    task automatic test_random();
        step(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int c;
            bit v, r;
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            c = (($urandom % 8) == 0) ? int'($urandom % 256) : m_exp;
            step(c, v, r, 0);
            checks++; if (smp_vld_o !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_vld cyc=%0d got %0b want %0b", i, smp_vld_o, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if (smp_data_o !== 8'(m_q[0])) begin errors++; $display("FAIL rnd_data cyc=%0d got %0d want %0d", i, smp_data_o, m_q[0]); end
            end
            checks++; if (err_o !== m_err || err_cnt_o !== 8'(m_errcnt)) begin
                errors++; $display("FAIL rnd_err cyc=%0d got %0b/%0d want %0b/%0d", i, err_o, err_cnt_o, m_err, m_errcnt);
            end
            checks++; if (ovf_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got %0b want %0b", i, ovf_o, m_ovf); end
        end
    endtask

    task automatic test_free_run();
        step(0, 0, 0, 1);
        step(20, 0, 1, 0);
        free_run = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0);
            checks++; if (smp_vld_o !== 1'b1 || smp_data_o !== 8'(m_q[0])) begin
                errors++; $display("FAIL fr_data cyc=%0d got %0d want %0d", i, smp_data_o, m_q[0]);
            end
            checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fr_err cyc=%0d got %0b want 0", i, err_o); end
        end
        free_run = 0;
    endtask

    initial begin
        free_run = 0; cnt_drv = '0; cnt_vld_i = 0; smp_rdy_i = 0; rst = 1;
        test_reset();
        test_basic();
        test_wrap();
        test_skip();
        test_overflow();
        test_saturate();
        test_reset_mid();
        test_random();
        test_free_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
